// File: rtl/n0prime_calc.sv
// Iterative Montgomery word constant: n0prime = -n0^-1 mod 2^WIDTH.
// One bit of the result per cycle; t tracks n0*x so far and is driven towards all-ones.
module n0prime_calc #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] n0,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] n0prime
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] KLAST = CNT_WIDTH'(WIDTH - 1);

  state_t               state;
  state_t               state_next;
  logic [WIDTH-1:0]     n0_q;
  logic [WIDTH-1:0]     t;
  logic [WIDTH-1:0]     x;
  logic [WIDTH-1:0]     t_next;
  logic [WIDTH-1:0]     x_next;
  logic [WIDTH-1:0]     onehot;
  logic                 tbit;
  logic [CNT_WIDTH-1:0] k;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = n0[0] ? RUN : DONE;
      RUN:     if (k == KLAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bit k of t must end up 1; adding n0<<k (n0 odd) flips exactly that bit.
  always_comb begin
    onehot = WIDTH'(1) << k;
    tbit   = |(t & onehot);
    t_next = t;
    x_next = x;
    if (!tbit) begin
      t_next = t + (n0_q << k);
      x_next = x | onehot;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n0_q    <= '0;
      t       <= '0;
      x       <= '0;
      k       <= '0;
      err     <= 1'b0;
      n0prime <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (n0[0]) begin
              n0_q <= n0;
              t    <= '0;
              x    <= '0;
              k    <= '0;
              err  <= 1'b0;
            end else begin
              err     <= 1'b1;
              n0prime <= '0;
            end
          end
        end
        RUN: begin
          t <= t_next;
          x <= x_next;
          // Result is published only once complete, including the last bit.
          if (k == KLAST) n0prime <= x_next;
          else            k <= k + CNT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_n0prime_calc.sv
// Directed and scoreboard bench for n0prime_calc (WIDTH=32).
// Results are checked against hand-computed constants and the defining identity n0*n0prime = -1.
module tb_n0prime_calc;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] n0;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] n0prime;

  int checks   = 0;
  int failures = 0;

  n0prime_calc #(.WIDTH(WIDTH), .CNT_WIDTH(6)) dut (
    .clk(clk), .reset(reset), .start(start), .n0(n0),
    .busy(busy), .done(done), .err(err), .n0prime(n0prime)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Start one computation; lat counts cycles from accept edge to the done cycle.
  task automatic applyStimulus(input logic [WIDTH-1:0] val, output logic [WIDTH-1:0] res,
                               output logic e, output int lat, output int busyCnt);
    logic [WIDTH-1:0] prev;
    int unstable;
    prev     = n0prime;
    unstable = 0;
    @(negedge clk);
    start = 1'b1;
    n0    = val;
    @(posedge clk);
    #1;
    start   = 1'b0;
    n0      = ~val;
    lat     = 1;
    busyCnt = 0;
    while (!done && lat < 100) begin
      if (busy) busyCnt++;
      if (n0prime !== prev) unstable++;
      if (lat == 5) start = 1'b1;
      if (lat == 6) start = 1'b0;
      n0 = $urandom;
      @(posedge clk);
      #1;
      lat++;
    end
    if (lat >= 100) checkOutput("done_timeout", 64'(lat), 64'(WIDTH + 1));
    checkOutput("result_stable_in_run", 64'(unstable), 64'd0);
    res = n0prime;
    e   = err;
    @(posedge clk);
    #1;
    checkOutput("done_one_cycle", 64'(done), 64'd0);
  endtask

  task automatic runOdd(input string tag, input logic [WIDTH-1:0] val, input logic [WIDTH-1:0] expRes);
    logic [WIDTH-1:0] res;
    logic e;
    int lat, bc;
    applyStimulus(val, res, e, lat, bc);
    checkOutput({tag, "_result"}, 64'(res), 64'(expRes));
    checkOutput({tag, "_err"}, 64'(e), 64'd0);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(WIDTH + 1));
    checkOutput({tag, "_busy_cycles"}, 64'(bc), 64'(WIDTH));
  endtask

  initial begin
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] rnd;
    logic [63:0]      prod;
    logic             e;
    int               lat, bc, cyc;

    reset = 1'b1;
    start = 1'b0;
    n0    = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_err", 64'(err), 64'd0);
    checkOutput("reset_n0prime", 64'(n0prime), 64'd0);
    reset = 1'b0;

    runOdd("n0_1", 32'h00000001, 32'hFFFFFFFF);
    runOdd("n0_3", 32'h00000003, 32'h55555555);
    runOdd("n0_5", 32'h00000005, 32'h33333333);
    runOdd("n0_7", 32'h00000007, 32'h49249249);
    runOdd("n0_ffffffff", 32'hFFFFFFFF, 32'h00000001);

    applyStimulus(32'h00000002, res, e, lat, bc);
    checkOutput("even_err", 64'(e), 64'd1);
    checkOutput("even_n0prime", 64'(res), 64'd0);
    checkOutput("even_latency", 64'(lat), 64'd1);
    checkOutput("even_busy_cycles", 64'(bc), 64'd0);

    runOdd("n0_3_after_even", 32'h00000003, 32'h55555555);

    // Reset during cycle C+10 of a run, with a start request in the same cycle.
    @(negedge clk);
    start = 1'b1;
    n0    = 32'h00000003;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    n0    = 32'h00000001;
    @(posedge clk);
    #1;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_err", 64'(err), 64'd0);
    checkOutput("abort_n0prime", 64'(n0prime), 64'd0);
    reset = 1'b0;
    start = 1'b0;
    cyc   = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) cyc++;
    end
    checkOutput("abort_no_done", 64'(cyc), 64'd0);
    runOdd("n0_3_after_abort", 32'h00000003, 32'h55555555);

    // Start held high with n0 changing every cycle after each accept.
    @(negedge clk);
    start = 1'b1;
    n0    = 32'h00000003;
    @(posedge clk);
    #1;
    cyc = 1;
    while (!done && cyc < 100) begin
      n0 = $urandom;
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("hold1_latency", 64'(cyc), 64'(WIDTH + 1));
    checkOutput("hold1_result", 64'(n0prime), 64'h55555555);
    n0 = 32'h00000005;
    @(posedge clk);
    #1;
    checkOutput("hold_idle_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("hold_restart_busy", 64'(busy), 64'd1);
    cyc = 1;
    while (!done && cyc < 100) begin
      n0 = $urandom;
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("hold2_latency", 64'(cyc), 64'(WIDTH + 1));
    checkOutput("hold2_result", 64'(n0prime), 64'h33333333);
    start = 1'b0;
    @(posedge clk);
    #1;

    // Random odd moduli checked by the defining identity.
    for (int i = 0; i < 200; i++) begin
      rnd = $urandom | 32'h1;
      applyStimulus(rnd, res, e, lat, bc);
      prod = 64'(rnd) * 64'(res);
      checkOutput("rand_identity", {32'd0, prod[31:0]}, 64'hFFFFFFFF);
      checkOutput("rand_latency", 64'(lat), 64'(WIDTH + 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
